// File: rtl/controle_entrada.sv
// Inlet valve sequencer: debounces the tank level sensors and runs ESPERA/ENCHENDO/CHEIO/ERRO.
// Filter settles DEB_CYC edges after a stable raw change; state and outputs follow one edge later.
module controle_entrada #(
   parameter int DEB_CYC      = 4,
   parameter int FILL_TIMEOUT = 1000,
   parameter int MIN_OFF      = 16,
   parameter int CNT_W        = 16
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Sb,
   input  logic       Sm,
   input  logic       Sa,
   input  logic       Clear,
   output logic       Ve,
   output logic       Erro,
   output logic [1:0] Estado
);

   typedef enum logic [1:0] {
      ESPERA   = 2'b00,
      ENCHENDO = 2'b01,
      CHEIO    = 2'b10,
      ERRO     = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
   localparam logic [CNT_W-1:0] MIN_OFF_C = CNT_W'(MIN_OFF);
   localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [2:0]       filt_q, filt_d;   // {fSa, fSm, fSb}
   logic [CNT_W-1:0] deb_q [3];
   logic [CNT_W-1:0] deb_d [3];
   logic [CNT_W-1:0] off_q, off_d;
   logic [CNT_W-1:0] fill_q, fill_d;
   logic [2:0]       raw;
   logic             fsb, fsm, fsa;
   logic             incons;

   assign raw = {Sa, Sm, Sb};
   assign fsb = filt_q[0];
   assign fsm = filt_q[1];
   assign fsa = filt_q[2];

   // A higher mark reading wet while a lower one reads dry cannot happen physically.
   assign incons = (fsa & ~fsm) | (fsa & ~fsb) | (fsm & ~fsb);

   always_comb begin
      filt_d = filt_q;
      for (int i = 0; i < 3; i++) begin
         deb_d[i] = '0;
         if (raw[i] != filt_q[i]) begin
            if (deb_q[i] == DEB_LAST) begin
               filt_d[i] = raw[i];
            end else begin
               deb_d[i] = deb_q[i] + ONE;
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ESPERA: begin
            if (incons) begin
               state_d = ERRO;
            end else if (!fsb && (off_q == MIN_OFF_C)) begin
               state_d = ENCHENDO;
            end
         end
         ENCHENDO: begin
            if (incons) begin
               state_d = ERRO;
            end else if (fsa) begin
               state_d = CHEIO;
            end else if (fill_q == FILL_LAST) begin
               state_d = ERRO;
            end
         end
         CHEIO: begin
            if (incons) begin
               state_d = ERRO;
            end else if (!fsb) begin
               state_d = ESPERA;
            end
         end
         ERRO: begin
            if (Clear && !incons) begin
               state_d = ESPERA;
            end
         end
      endcase
   end

   // Valve-closed time accumulates only while idle or full; any fill or error restarts it.
   always_comb begin
      off_d = '0;
      if ((state_q == ESPERA) || (state_q == CHEIO)) begin
         off_d = (off_q == MIN_OFF_C) ? off_q : off_q + ONE;
      end
   end

   always_comb begin
      fill_d = fill_q;
      if ((state_q != ENCHENDO) && (state_d == ENCHENDO)) begin
         fill_d = '0;
      end else if (state_q == ENCHENDO) begin
         fill_d = fill_q + ONE;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= ESPERA;
         filt_q  <= '0;
         for (int i = 0; i < 3; i++) begin
            deb_q[i] <= '0;
         end
         off_q   <= '0;
         fill_q  <= '0;
         Ve      <= 1'b0;
         Erro    <= 1'b0;
         Estado  <= 2'b00;
      end else begin
         state_q <= state_d;
         filt_q  <= filt_d;
         for (int i = 0; i < 3; i++) begin
            deb_q[i] <= deb_d[i];
         end
         off_q   <= off_d;
         fill_q  <= fill_d;
         Ve      <= (state_d == ENCHENDO);
         Erro    <= (state_d == ERRO);
         Estado  <= state_d;
      end
   end

endmodule

// File: tb/tb_controle_entrada.sv
// Bench for controle_entrada: timed expectations queued at stimulus time, compared at negedge.
module tb_controle_entrada;

   localparam logic [3:0] ST_ESP = 4'b0000;  // {Ve, Erro, Estado}
   localparam logic [3:0] ST_ENC = 4'b1001;
   localparam logic [3:0] ST_CHE = 4'b0010;
   localparam logic [3:0] ST_ERR = 4'b0111;

   logic       Clock = 1'b0;
   logic       Reset, Sb, Sm, Sa, Clear;
   logic       Ve, Erro;
   logic [1:0] Estado;

   typedef struct {
      string       tag;
      int unsigned at;
      logic [3:0]  exp;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned edges = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 Clock = ~Clock;

   controle_entrada #(
      .DEB_CYC(4), .FILL_TIMEOUT(50), .MIN_OFF(16), .CNT_W(16)
   ) dut (
      .Clock(Clock), .Reset(Reset), .Sb(Sb), .Sm(Sm), .Sa(Sa), .Clear(Clear),
      .Ve(Ve), .Erro(Erro), .Estado(Estado)
   );

   always @(posedge Clock) edges <= edges + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edges, obs, exp);
      end
   endtask

   task automatic expect_rng(input string tag, input int unsigned from, input int unsigned to,
                             input logic [3:0] v);
      for (int unsigned e = from; e <= to; e++) begin
         sb_q.push_back('{tag: tag, at: e, exp: v});
      end
   endtask

   // Returns 1 time unit after edge e, so anything driven next is first sampled at edge e+1.
   task automatic goto(input int unsigned e);
      while (edges < e) begin
         @(posedge Clock);
         #1;
      end
   endtask

   always @(negedge Clock) begin
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
         if (sb_q[i].at == edges) begin
            chk(sb_q[i].tag, {28'd0, Ve, Erro, Estado}, {28'd0, sb_q[i].exp});
            sb_q.delete(i);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned rel, en, s, b, e2, c, e3, a, e4, r;
      Reset = 1'b1; Sb = 1'b0; Sm = 1'b0; Sa = 1'b0; Clear = 1'b0;
      expect_rng("rst", 1, 3, ST_ESP);
      goto(1);
      chk("rst_filt", 32'(dut.filt_q), 32'd0);
      goto(3);
      Reset = 1'b0;
      rel = 4;
      expect_rng("idle", rel, rel + 15, ST_ESP);
      expect_rng("open", rel + 16, rel + 16, ST_ENC);
      en = rel + 16;

      // Glitch on Sa, then fill Sb -> Sm -> Sa
      goto(en);
      expect_rng("fill", en + 1, en + 29, ST_ENC);
      Sa = 1'b1;
      goto(en + 3);  Sa = 1'b0;
      goto(en + 5);  Sb = 1'b1;
      goto(en + 15); Sm = 1'b1;
      goto(en + 25); Sa = 1'b1;
      s = en + 26;
      b = s + 34;
      expect_rng("full", s + 4, b + 3, ST_CHE);
      expect_rng("drain", b + 4, b + 4, ST_ESP);
      expect_rng("refill", b + 5, b + 5, ST_ENC);
      goto(s + 13);  Sa = 1'b0;
      goto(s + 23);  Sm = 1'b0;
      goto(s + 33);  Sb = 1'b0;

      // Fill timeout with all sensors dry
      e2 = b + 5;
      expect_rng("tmo_fill", e2 + 1, e2 + 49, ST_ENC);
      expect_rng("tmo_err", e2 + 50, e2 + 52, ST_ERR);
      goto(e2 + 52);
      Clear = 1'b1;
      c = e2 + 53;
      expect_rng("clr_off", c, c + 16, ST_ESP);
      expect_rng("clr_open", c + 17, c + 17, ST_ENC);
      goto(c);       Clear = 1'b0;
      goto(c + 4);   Clear = 1'b1;
      goto(c + 5);   Clear = 1'b0;

      // Inconsistent sensors: Sa wet with Sb/Sm dry
      e3 = c + 17;
      goto(e3 + 1);
      Sa = 1'b1;
      a = e3 + 2;
      expect_rng("inc_pre", e3 + 1, a + 3, ST_ENC);
      expect_rng("inc_err", a + 4, a + 15, ST_ERR);
      expect_rng("inc_clr", a + 16, a + 32, ST_ESP);
      expect_rng("inc_open", a + 33, a + 33, ST_ENC);
      goto(a + 6);   Clear = 1'b1;
      goto(a + 7);   Clear = 1'b0;
      goto(a + 10);  Sa = 1'b0;
      goto(a + 15);  Clear = 1'b1;
      goto(a + 16);  Clear = 1'b0;

      // Reset in the middle of a fill with Sb/Sm wet
      e4 = a + 33;
      goto(e4);
      Sb = 1'b1; Sm = 1'b1;
      expect_rng("mid_fill", e4 + 1, e4 + 7, ST_ENC);
      goto(e4 + 7);
      Reset = 1'b1;
      r = e4 + 8;
      expect_rng("mid_rst", r, r + 34, ST_ESP);
      expect_rng("rst_refill", r + 35, r + 35, ST_ENC);
      goto(r);
      chk("mid_rst_filt", 32'(dut.filt_q), 32'd0);
      Reset = 1'b0;
      goto(r + 20);  Sm = 1'b0;
      goto(r + 30);  Sb = 1'b0;
      goto(r + 40);

      chk("leftover", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
